// File: rtl/rv32i_types_pkg.sv
// Shared RV32I types for the load/store path: access width/sign encoding and byte-lane masks.
package rv32i_types_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;
  localparam int unsigned BE_W  = XLEN / 8;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_t;

  localparam logic [BE_W-1:0] BE_BYTE0   = 4'b0001;
  localparam logic [BE_W-1:0] BE_BYTE1   = 4'b0010;
  localparam logic [BE_W-1:0] BE_BYTE2   = 4'b0100;
  localparam logic [BE_W-1:0] BE_BYTE3   = 4'b1000;
  localparam logic [BE_W-1:0] BE_HALF_LO = 4'b0011;
  localparam logic [BE_W-1:0] BE_HALF_HI = 4'b1100;
  localparam logic [BE_W-1:0] BE_WORD    = 4'b1111;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane generation, store-data replication, load extraction/extension and alignment check.
module lsu_align
  import rv32i_types_pkg::*;
(
  input  logic [1:0]      addr_lo,
  input  load_t           load_type,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] rdata,
  output logic [BE_W-1:0] byte_en_c,
  output logic [XLEN-1:0] wdata_c,
  output logic [XLEN-1:0] load_data_c,
  output logic            misaligned_c
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    shifted      = rdata >> {addr_lo, 3'b000};
    byte_en_c    = BE_WORD;
    wdata_c      = store_data;
    load_data_c  = shifted;
    misaligned_c = 1'b0;
    unique case (load_type)
      LB, LBU: begin
        unique case (addr_lo)
          2'd0:    byte_en_c = BE_BYTE0;
          2'd1:    byte_en_c = BE_BYTE1;
          2'd2:    byte_en_c = BE_BYTE2;
          default: byte_en_c = BE_BYTE3;
        endcase
        wdata_c     = {4{store_data[7:0]}};
        load_data_c = (load_type == LB) ? {{24{shifted[7]}}, shifted[7:0]}
                                        : {24'h0, shifted[7:0]};
      end
      LH, LHU: begin
        misaligned_c = addr_lo[0];
        byte_en_c    = addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
        wdata_c      = {2{store_data[15:0]}};
        load_data_c  = (load_type == LH) ? {{16{shifted[15]}}, shifted[15:0]}
                                         : {16'h0, shifted[15:0]};
      end
      // LW and unused encodings behave as a full-word access
      default: begin
        misaligned_c = (addr_lo != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// Memory stage of the load/store unit: one outstanding bus access, registered bus and writeback outputs.
module lsu_mem_stage
  import rv32i_types_pkg::*;
(
  input  logic             CLK,
  input  logic             nRST,
  input  logic [XLEN-1:0]  addr,
  input  logic [XLEN-1:0]  store_data,
  input  load_t            load_type,
  input  logic             dren_ls,
  input  logic             dwen_ls,
  input  logic             wen_ls,
  input  logic [REG_W-1:0] reg_rd_ls,
  output logic [XLEN-1:0]  bus_addr,
  output logic             bus_ren,
  output logic             bus_wen,
  output logic [BE_W-1:0]  bus_byte_en,
  output logic [XLEN-1:0]  bus_wdata,
  input  logic [XLEN-1:0]  bus_rdata,
  input  logic             bus_busy,
  output logic             lsu_stall,
  output logic             wb_valid,
  output logic             wb_wen,
  output logic [REG_W-1:0] wb_rd,
  output logic [XLEN-1:0]  wb_data,
  output logic             misaligned_ld,
  output logic             misaligned_st
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t           state, state_d;
  logic [1:0]       lat_addr_lo, lat_addr_lo_d;
  load_t            lat_type, lat_type_d;
  logic [REG_W-1:0] lat_rd, lat_rd_d;
  logic [XLEN-1:0]  bus_addr_d, bus_wdata_d, wb_data_d;
  logic [BE_W-1:0]  bus_byte_en_d;
  logic [REG_W-1:0] wb_rd_d;
  logic             bus_ren_d, bus_wen_d, wb_valid_d, wb_wen_d;
  logic             misaligned_ld_d, misaligned_st_d;

  logic [1:0]       al_addr_lo;
  load_t            al_type;
  logic [BE_W-1:0]  al_byte_en_c;
  logic [XLEN-1:0]  al_wdata_c, al_load_data_c;
  logic             al_misaligned_c;

  // In IDLE the aligner looks at the incoming request, in ACCESS at the latched one
  assign al_addr_lo = (state == IDLE) ? addr[1:0] : lat_addr_lo;
  assign al_type    = (state == IDLE) ? load_type : lat_type;

  lsu_align u_align (
    .addr_lo      (al_addr_lo),
    .load_type    (al_type),
    .store_data   (store_data),
    .rdata        (bus_rdata),
    .byte_en_c    (al_byte_en_c),
    .wdata_c      (al_wdata_c),
    .load_data_c  (al_load_data_c),
    .misaligned_c (al_misaligned_c)
  );

  assign lsu_stall = (state == ACCESS);

  always_comb begin
    state_d         = state;
    lat_addr_lo_d   = lat_addr_lo;
    lat_type_d      = lat_type;
    lat_rd_d        = lat_rd;
    bus_addr_d      = bus_addr;
    bus_ren_d       = 1'b0;
    bus_wen_d       = 1'b0;
    bus_byte_en_d   = bus_byte_en;
    bus_wdata_d     = bus_wdata;
    wb_valid_d      = 1'b0;
    wb_wen_d        = 1'b0;
    wb_rd_d         = wb_rd;
    wb_data_d       = wb_data;
    misaligned_ld_d = 1'b0;
    misaligned_st_d = 1'b0;
    unique case (state)
      IDLE: begin
        if (dren_ls || dwen_ls) begin
          // A simultaneous load and store request is served as a load
          if (al_misaligned_c) begin
            misaligned_ld_d = dren_ls;
            misaligned_st_d = !dren_ls;
          end else begin
            state_d       = ACCESS;
            lat_addr_lo_d = addr[1:0];
            lat_type_d    = load_type;
            lat_rd_d      = reg_rd_ls;
            bus_addr_d    = {addr[XLEN-1:2], 2'b00};
            bus_ren_d     = dren_ls;
            bus_wen_d     = !dren_ls;
            bus_byte_en_d = al_byte_en_c;
            bus_wdata_d   = al_wdata_c;
          end
        end else if (wen_ls) begin
          wb_valid_d = 1'b1;
          wb_wen_d   = 1'b1;
          wb_rd_d    = reg_rd_ls;
          wb_data_d  = addr;
        end
      end
      ACCESS: begin
        bus_ren_d = bus_ren;
        bus_wen_d = bus_wen;
        if (!bus_busy) begin
          state_d    = IDLE;
          bus_ren_d  = 1'b0;
          bus_wen_d  = 1'b0;
          wb_valid_d = 1'b1;
          wb_wen_d   = bus_ren;
          wb_rd_d    = lat_rd;
          if (bus_ren) wb_data_d = al_load_data_c;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state         <= IDLE;
      lat_addr_lo   <= 2'b00;
      lat_type      <= LB;
      lat_rd        <= '0;
      bus_addr      <= '0;
      bus_ren       <= 1'b0;
      bus_wen       <= 1'b0;
      bus_byte_en   <= '0;
      bus_wdata     <= '0;
      wb_valid      <= 1'b0;
      wb_wen        <= 1'b0;
      wb_rd         <= '0;
      wb_data       <= '0;
      misaligned_ld <= 1'b0;
      misaligned_st <= 1'b0;
    end else begin
      state         <= state_d;
      lat_addr_lo   <= lat_addr_lo_d;
      lat_type      <= lat_type_d;
      lat_rd        <= lat_rd_d;
      bus_addr      <= bus_addr_d;
      bus_ren       <= bus_ren_d;
      bus_wen       <= bus_wen_d;
      bus_byte_en   <= bus_byte_en_d;
      bus_wdata     <= bus_wdata_d;
      wb_valid      <= wb_valid_d;
      wb_wen        <= wb_wen_d;
      wb_rd         <= wb_rd_d;
      wb_data       <= wb_data_d;
      misaligned_ld <= misaligned_ld_d;
      misaligned_st <= misaligned_st_d;
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage with a writeback scoreboard.
module tb_lsu_mem_stage;
  import rv32i_types_pkg::*;

  logic        CLK, nRST;
  logic [31:0] addr, store_data, bus_rdata;
  load_t       load_type;
  logic        dren_ls, dwen_ls, wen_ls, bus_busy;
  logic [4:0]  reg_rd_ls;
  logic [31:0] bus_addr, bus_wdata, wb_data;
  logic        bus_ren, bus_wen, lsu_stall, wb_valid, wb_wen;
  logic [3:0]  bus_byte_en;
  logic [4:0]  wb_rd;
  logic        misaligned_ld, misaligned_st;

  typedef struct packed {
    logic        wen;
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_exp_t;

  wb_exp_t sb_q[$];
  int vectors = 0;
  int miscompares = 0;

  lsu_mem_stage dut (
    .CLK(CLK), .nRST(nRST), .addr(addr), .store_data(store_data), .load_type(load_type),
    .dren_ls(dren_ls), .dwen_ls(dwen_ls), .wen_ls(wen_ls), .reg_rd_ls(reg_rd_ls),
    .bus_addr(bus_addr), .bus_ren(bus_ren), .bus_wen(bus_wen), .bus_byte_en(bus_byte_en),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_busy(bus_busy), .lsu_stall(lsu_stall),
    .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
    .misaligned_ld(misaligned_ld), .misaligned_st(misaligned_st)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every writeback pulse must match the oldest expectation
  always @(negedge CLK) begin
    if (nRST && wb_valid) begin
      if (sb_q.size() == 0) begin
        chk("wb_unexpected", 32'(wb_valid), 32'h0);
      end else begin
        wb_exp_t e;
        e = sb_q.pop_front();
        chk("wb_wen", 32'(wb_wen), 32'(e.wen));
        if (e.wen) begin
          chk("wb_rd", 32'(wb_rd), 32'(e.rd));
          chk("wb_data", wb_data, e.data);
        end
      end
    end
  end

  task automatic idle_inputs();
    dren_ls = 1'b0; dwen_ls = 1'b0; wen_ls = 1'b0;
    addr = 32'h0; store_data = 32'h0; load_type = LW; reg_rd_ls = 5'd0;
  endtask

  // Called at a negedge; returns at a negedge one cycle after the writeback pulse
  task automatic access(input logic dr, input logic dw, input load_t t, input logic [31:0] a,
                        input logic [31:0] sd, input logic [31:0] rdat, input logic [4:0] rd,
                        input int busy_n, input logic [3:0] exp_be, input logic [31:0] exp_wd,
                        input logic [31:0] exp_wb);
    int stall_cnt;
    wb_exp_t e;
    stall_cnt = 0;
    dren_ls = dr; dwen_ls = dw; load_type = t; addr = a; store_data = sd; reg_rd_ls = rd;
    bus_busy = 1'b1;
    e.wen = dr; e.rd = rd; e.data = exp_wb;
    sb_q.push_back(e);
    @(negedge CLK);
    for (int i = 0; i <= busy_n; i++) begin
      stall_cnt += int'(lsu_stall);
      chk("bus_ren", 32'(bus_ren), 32'(dr));
      chk("bus_wen", 32'(bus_wen), 32'(!dr));
      chk("bus_addr", bus_addr, {a[31:2], 2'b00});
      chk("bus_byte_en", 32'(bus_byte_en), 32'(exp_be));
      if (!dr) chk("bus_wdata", bus_wdata, exp_wd);
      bus_busy = (i < busy_n);
      bus_rdata = rdat;
      @(negedge CLK);
    end
    chk("stall_cycles", 32'(stall_cnt), 32'(busy_n + 1));
    chk("stall_after", 32'(lsu_stall), 32'h0);
    chk("strobes_after", {30'h0, bus_ren, bus_wen}, 32'h0);
    chk("wb_valid_pulse", 32'(wb_valid), 32'h1);
    idle_inputs();
    bus_busy = 1'b0;
    @(negedge CLK);
    chk("wb_valid_one_cycle", 32'(wb_valid), 32'h0);
  endtask

  task automatic misaligned(input logic dr, input logic dw, input load_t t, input logic [31:0] a);
    dren_ls = dr; dwen_ls = dw; load_type = t; addr = a; reg_rd_ls = 5'd9;
    @(negedge CLK);
    chk("mis_ld", 32'(misaligned_ld), 32'(dr));
    chk("mis_st", 32'(misaligned_st), 32'(!dr));
    chk("mis_no_strobe", {30'h0, bus_ren, bus_wen}, 32'h0);
    chk("mis_no_stall", 32'(lsu_stall), 32'h0);
    chk("mis_no_wb", 32'(wb_valid), 32'h0);
    idle_inputs();
    @(negedge CLK);
    chk("mis_pulse_end", {30'h0, misaligned_ld, misaligned_st}, 32'h0);
  endtask

  initial begin
    nRST = 1'b0;
    idle_inputs();
    bus_busy = 1'b0;
    bus_rdata = 32'h0;
    @(negedge CLK);
    @(negedge CLK);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_strobes", {30'h0, bus_ren, bus_wen}, 32'h0);
    chk("rst_byte_en", 32'(bus_byte_en), 32'h0);
    chk("rst_wdata", bus_wdata, 32'h0);
    chk("rst_wb", {25'h0, wb_valid, wb_wen, wb_rd}, 32'h0);
    chk("rst_wb_data", wb_data, 32'h0);
    chk("rst_mis_stall", {29'h0, misaligned_ld, misaligned_st, lsu_stall}, 32'h0);

    // Release reset and issue a request straight away
    nRST = 1'b1;
    access(1'b1, 1'b0, LB, 32'h0000_0103, 32'h0, 32'h80FF_0000, 5'd5, 0, 4'b1000, 32'h0, 32'hFFFF_FF80);
    access(1'b0, 1'b1, LB, 32'h0000_0202, 32'h0000_00A5, 32'h0, 5'd6, 3, 4'b0100, 32'hA5A5_A5A5, 32'h0);
    access(1'b1, 1'b0, LHU, 32'h0000_0102, 32'h0, 32'hBEEF_1234, 5'd7, 0, 4'b1100, 32'h0, 32'h0000_BEEF);
    misaligned(1'b1, 1'b0, LW, 32'h0000_0101);
    access(1'b1, 1'b1, LW, 32'h0000_0000, 32'h1111_2222, 32'hCAFE_F00D, 5'd8, 1, 4'b1111, 32'h0, 32'hCAFE_F00D);
    access(1'b1, 1'b0, LH, 32'h0000_0010, 32'h0, 32'h0000_8001, 5'd10, 0, 4'b0011, 32'h0, 32'hFFFF_8001);
    access(1'b1, 1'b0, LBU, 32'h0000_0021, 32'h0, 32'h0000_9A00, 5'd11, 2, 4'b0010, 32'h0, 32'h0000_009A);
    access(1'b0, 1'b1, LH, 32'h0000_0302, 32'h0000_BEEF, 32'h0, 5'd0, 0, 4'b1100, 32'hBEEF_BEEF, 32'h0);
    access(1'b0, 1'b1, LW, 32'h0000_0400, 32'h1234_5678, 32'h0, 5'd0, 1, 4'b1111, 32'h1234_5678, 32'h0);
    misaligned(1'b0, 1'b1, LH, 32'h0000_0201);
    misaligned(1'b1, 1'b0, LHU, 32'h0000_0003);

    // Register-only writeback bypasses the bus
    begin
      wb_exp_t e;
      wen_ls = 1'b1; addr = 32'hDEAD_BEEC; reg_rd_ls = 5'd12;
      e.wen = 1'b1; e.rd = 5'd12; e.data = 32'hDEAD_BEEC;
      sb_q.push_back(e);
      @(negedge CLK);
      chk("alu_wb_valid", 32'(wb_valid), 32'h1);
      chk("alu_no_stall", 32'(lsu_stall), 32'h0);
      chk("alu_no_strobe", {30'h0, bus_ren, bus_wen}, 32'h0);
      idle_inputs();
      @(negedge CLK);
      chk("alu_wb_one_cycle", 32'(wb_valid), 32'h0);
    end

    // Reset in the middle of a stalled access aborts it without writeback
    dren_ls = 1'b1; load_type = LW; addr = 32'h0000_0040; reg_rd_ls = 5'd13; bus_busy = 1'b1;
    @(negedge CLK);
    chk("abort_pre_ren", 32'(bus_ren), 32'h1);
    #2 nRST = 1'b0;
    #1;
    chk("abort_strobes", {30'h0, bus_ren, bus_wen}, 32'h0);
    chk("abort_stall", 32'(lsu_stall), 32'h0);
    chk("abort_wb", 32'(wb_valid), 32'h0);
    idle_inputs();
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    chk("abort_no_wb", 32'(wb_valid), 32'h0);
    bus_busy = 1'b0;
    access(1'b1, 1'b0, LW, 32'h0000_0000, 32'h0, 32'h1234_5678, 5'd14, 0, 4'b1111, 32'h0, 32'h1234_5678);

    chk("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lsu_mem_stage.md
LSU_MEM_STAGE -- requirements
Module: lsu_mem_stage

Interface
REQ-001 The block SHALL have one clock and one reset: reset is asynchronous and active-low, ports named CLK and nRST.
REQ-002 CLK  input  1  rising-edge clock.
REQ-003 nRST  input  1  asynchronous active-low reset.
REQ-004 addr  input  32  effective address (wdata_ls of execute stage).
REQ-005 store_data  input  32  store operand, low-aligned.
REQ-006 load_type  input  load_t  width and sign: LB/LBU byte, LH/LHU half, LW word; also selects store width.
REQ-007 dren_ls, dwen_ls, wen_ls  input  1 each  load request, store request, register-write request.
REQ-008 reg_rd_ls  input  5  destination register.
REQ-009 bus_addr  output  32  word-aligned address (addr[1:0] forced 0).
REQ-010 bus_ren, bus_wen  output  1 each  bus read/write strobes.
REQ-011 bus_byte_en  output  4  active byte lanes.
REQ-012 bus_wdata  output  32  lane-replicated store data.
REQ-013 bus_rdata  input  32; bus_busy  input  1  access completes in any cycle with strobe high and bus_busy=0.
REQ-014 lsu_stall  output  1  upstream holds all inputs while high.
REQ-015 wb_valid, wb_wen  output  1 each; wb_rd  output  5; wb_data  output  32  writeback result.
REQ-016 misaligned_ld, misaligned_st  output  1 each  single-cycle exception pulses.

Function
REQ-017 FSM states SHALL be IDLE and ACCESS; lsu_stall SHALL equal (state==ACCESS).
REQ-018 IDLE, aligned dren_ls or dwen_ls: latch addr, lanes, wdata, reg_rd_ls, load_type; next state ACCESS.
REQ-019 dren_ls and dwen_ls both high SHALL be treated as a load; store suppressed.
REQ-020 ACCESS: bus_ren (load) or bus_wen (store) held high with stable bus_addr/byte_en/wdata until bus_busy=0; that cycle SHALL be the completion cycle, next state IDLE.
REQ-021 Byte lanes: byte = 1<<addr[1:0]; half = addr[1]?4'b1100:4'b0011; word = 4'b1111.
REQ-022 bus_wdata: byte replicated x4, half replicated x2, word as-is.
REQ-023 Load data SHALL be rdata>>(8*addr[1:0]), then sign-extended (LB, LH) or zero-extended (LBU, LHU) from bit 7/15.
REQ-024 Completion of load: next cycle wb_valid=1, wb_wen=1, wb_rd=latched rd, wb_data=extended value, for exactly one cycle.
REQ-025 Completion of store: next cycle wb_valid=1, wb_wen=0 for one cycle.
REQ-026 IDLE, wen_ls with no dren_ls/dwen_ls: next cycle wb_valid=1, wb_wen=1, wb_data=addr, wb_rd=reg_rd_ls; no stall.
REQ-027 Misaligned (LW/word store addr[1:0]!=0; half addr[0]!=0): no bus access, state stays IDLE, next cycle misaligned_ld or misaligned_st=1, wb_valid=0.
REQ-028 A new request in IDLE SHALL be accepted in the cycle right after completion (back-to-back), giving 2-cycle minimum load latency.
REQ-029 Strobes SHALL never be high in IDLE.

Reset
REQ-030 nRST low SHALL asynchronously force state IDLE and every output 0 (bus_ren, bus_wen, bus_byte_en, bus_addr, bus_wdata, wb_*, misaligned_*, lsu_stall), aborting any in-flight access with no writeback.
REQ-031 After nRST release, first request SHALL be accepted on the first rising edge.

Structure
REQ-032 load_t SHALL stay in rv32i_types_pkg; byte-enable constants (BE_BYTE0..3, BE_HALF_LO/HI, BE_WORD) SHALL be added there; FSM state enum local.
REQ-033 Lane generation, store replication and load extraction SHALL be one combinational sub-module, lsu_align.

Verification
REQ-034 LB addr 0x103, bus_rdata 0x80FF_0000, bus_busy 0 -> wb_data 0xFFFF_FF80, wb_valid one cycle, byte_en 4'b1000.
REQ-035 SB addr 0x202, store_data 0x0000_00A5, bus_busy 1 for 3 cycles -> bus_wdata 0xA5A5_A5A5, byte_en 4'b0100, lsu_stall 4 cycles, wb_wen 0.
REQ-036 LHU addr 0x102, bus_rdata 0xBEEF_1234 -> wb_data 0x0000_BEEF; LW addr 0x101 -> misaligned_ld pulse, no bus_ren.
REQ-037 dren_ls and dwen_ls together, addr 0x0 -> bus_ren=1, bus_wen=0, load writeback only.
REQ-038 nRST low mid-ACCESS with bus_busy=1 -> strobes 0 immediately, wb_valid stays 0, next LW addr 0x0 completes normally.
